// File: rtl/nn_stream_pkg.sv
// Shared types for the neural-network streaming datapath.
package nn_stream_pkg;
    localparam int ELEM_W = 16;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef enum logic {ORDER_FWD, ORDER_REV}   order_e;
    typedef enum logic {SER_IDLE, SER_STREAM}   ser_state_e;
endpackage

// File: rtl/serializer_lane.sv
// One lane: holds a LEN-element vector and presents the element selected by idx.
module serializer_lane #(
    parameter int N     = 16,
    parameter int LEN   = 3,
    parameter int IDX_W = $clog2(LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [LEN-1:0][N-1:0]   data_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [N-1:0]            elem_o
);
    logic [LEN-1:0][N-1:0] vec_q;

    always_ff @(posedge clk) begin
        if (rst)         vec_q <= '0;
        else if (load_i) vec_q <= data_i;
    end

    // Registered vector muxed by registered index: no path from data_i to elem_o.
    assign elem_o = vec_q[idx_i];
endmodule

// File: rtl/vector_serializer.sv
// Parallel-to-serial vector streamer with replay, order select and valid/ready on both sides.
module vector_serializer
    import nn_stream_pkg::*;
#(
    parameter int   N     = 16,
    parameter int   LEN   = 3,
    parameter int   CH    = 1,
    parameter int   REP_W = 8,
    localparam int  IDX_W = $clog2(LEN)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CH-1:0][LEN-1:0][N-1:0] in_data,
    input  logic                          in_reverse,
    input  logic [REP_W-1:0]              in_reps,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH-1:0][N-1:0]          out_data,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last_elem,
    output logic                          out_last,
    output logic                          busy
);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);

    ser_state_e         state_q, state_d;
    order_e             ord_q, ord_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               fire, load, last_elem;
    logic [CH-1:0][N-1:0] lane_elem;

    assign out_valid     = (state_q == SER_STREAM);
    assign busy          = out_valid;
    assign last_elem     = out_valid && ((ord_q == ORDER_REV) ? (idx_q == '0) : (idx_q == IDX_LAST));
    assign out_last_elem = last_elem;
    assign out_last      = last_elem && (reps_q == REP_W'(1));
    assign fire          = out_valid && out_ready;
    // Ready also on the final accepted beat so the next vector follows without a gap.
    assign in_ready      = (state_q == SER_IDLE) || (fire && out_last);
    assign load          = in_valid && in_ready;
    assign out_idx       = idx_q;

    always_comb begin
        state_d = state_q;
        ord_d   = ord_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        if (load) begin
            state_d = SER_STREAM;
            ord_d   = in_reverse ? ORDER_REV : ORDER_FWD;
            idx_d   = in_reverse ? IDX_LAST : '0;
            reps_d  = (in_reps == '0) ? REP_W'(1) : in_reps;
        end else if (fire) begin
            if (last_elem) begin
                if (reps_q > REP_W'(1)) begin
                    reps_d = reps_q - REP_W'(1);
                    idx_d  = (ord_q == ORDER_REV) ? IDX_LAST : '0;
                end else begin
                    state_d = SER_IDLE;
                    idx_d   = '0;
                end
            end else begin
                idx_d = (ord_q == ORDER_REV) ? idx_q - IDX_W'(1) : idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            ord_q   <= ORDER_FWD;
            idx_q   <= '0;
            reps_q  <= '0;
        end else begin
            state_q <= state_d;
            ord_q   <= ord_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        serializer_lane #(.N(N), .LEN(LEN), .IDX_W(IDX_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .load_i (load),
            .data_i (in_data[c]),
            .idx_i  (idx_q),
            .elem_o (lane_elem[c])
        );
    end

    assign out_data = out_valid ? lane_elem : '0;
endmodule
